// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared types and constants for the sequential divider slice.
//   div_state_t        : controller states IDLE/LOAD/RUN/DONE
//   DIV_DEFAULT_WIDTH  : default operand width
//   clog2()            : ceil(log2(v)) for elaboration-time widths
// Optional feature macro used elsewhere in the slice: SIGNED_DIV_EN.
// -----------------------------------------------------------------------------
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int unsigned DIV_DEFAULT_WIDTH = 32'd8;

   // Smallest r with 2**r >= v; same result as $clog2 for v >= 1.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if: start/busy/done handshake bundle for seq_divider.
//   master drives : start, dividend, divisor (+ signed_op with SIGNED_DIV_EN)
//   slave drives  : busy, done, quotient, remainder, div_by_zero
// Macro SIGNED_DIV_EN adds the signed_op request bit.
// -----------------------------------------------------------------------------
interface seq_divider_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
   logic             signed_op;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
`ifdef SIGNED_DIV_EN
      output signed_op,
`endif
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
`ifdef SIGNED_DIV_EN
      input  signed_op,
`endif
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_step.sv
// -----------------------------------------------------------------------------
// div_step: one combinational restoring-division iteration.
//   i_a : partial remainder A (WIDTH+1)   o_a : next A
//   i_q : dividend/quotient Q (WIDTH)     o_q : next Q (new quotient bit in LSB)
//   i_m : divisor M (WIDTH)
// -----------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   i_a,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH:0]   o_a,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH+1:0] w_sh;
   logic [WIDTH+1:0] w_diff;
   logic             w_neg;

   // {A,Q} shifted left; one extra bit on top so the borrow of T is explicit.
   assign w_sh   = {i_a, i_q[WIDTH-1]};
   assign w_diff = w_sh - {2'b00, i_m};
   assign w_neg  = w_diff[WIDTH+1];

   // Restore A when T went negative; otherwise keep T and set the quotient bit.
   assign o_a = w_neg ? w_sh[WIDTH:0] : w_diff[WIDTH:0];
   assign o_q = {i_q[WIDTH-2:0], ~w_neg};
endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider: unsigned restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any division in flight)
//   bus   : seq_divider_if.slave (start/operands in; busy/done/results out)
// Latency start edge -> done: WIDTH+2 cycles, or 2 cycles on divide-by-zero.
// Results hold from one done to the next.
// Macro SIGNED_DIV_EN: signed_op selects two's-complement operands; magnitudes
// are taken in LOAD and signs restored in DONE, so latency is unchanged.
// -----------------------------------------------------------------------------
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_divider_if.slave bus
);
   localparam int CNT_W = clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_LOAD = LOAD;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
   localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic             r_dbz_pend;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;
   logic [WIDTH:0]   w_a_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_neg_q;
   logic             w_neg_r;

   // Two's-complement negation, used for sign fix-up and magnitudes.
   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

`ifdef SIGNED_DIV_EN
   logic r_sgn;
   logic r_neg_q;
   logic r_neg_r;
   assign w_neg_q = r_neg_q;
   assign w_neg_r = r_neg_r;
`else
   assign w_neg_q = 1'b0;
   assign w_neg_r = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_a (r_a),
      .i_q (r_q),
      .i_m (r_m),
      .o_a (w_a_nxt),
      .o_q (w_q_nxt)
   );

   // Next-state decode; start is only honoured in IDLE and DONE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) w_state_nxt = ST_LOAD;
            else           w_state_nxt = ST_IDLE;
         end
         ST_LOAD: begin
            if (r_m == W_ZERO) w_state_nxt = ST_DONE;
            else               w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (r_cnt == C_ONE) w_state_nxt = ST_DONE;
            else                w_state_nxt = ST_RUN;
         end
         ST_DONE: begin
            if (bus.start) w_state_nxt = ST_LOAD;
            else           w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath, controller state and registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= {CNT_W{1'b0}};
         r_a        <= {(WIDTH+1){1'b0}};
         r_q        <= W_ZERO;
         r_m        <= W_ZERO;
         r_dbz_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_quot     <= W_ZERO;
         r_rem      <= W_ZERO;
         r_dbz      <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_sgn      <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN);
         // done is the registered image of the DONE state: one cycle wide.
         r_done  <= (r_state == ST_DONE);

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  r_a <= {(WIDTH+1){1'b0}};
                  r_q <= bus.dividend;
                  r_m <= bus.divisor;
`ifdef SIGNED_DIV_EN
                  r_sgn <= bus.signed_op;
`endif
               end
            end
            ST_LOAD: begin
               r_cnt      <= CNT_W'(WIDTH);
               r_dbz_pend <= (r_m == W_ZERO);
`ifdef SIGNED_DIV_EN
               // Raw dividend is kept on divide-by-zero so the result
               // matches unsigned mode.
               if (r_sgn && (r_m != W_ZERO)) begin
                  r_q     <= r_q[WIDTH-1] ? f_neg(r_q) : r_q;
                  r_m     <= r_m[WIDTH-1] ? f_neg(r_m) : r_m;
                  r_neg_q <= r_q[WIDTH-1] ^ r_m[WIDTH-1];
                  r_neg_r <= r_q[WIDTH-1];
               end else begin
                  r_neg_q <= 1'b0;
                  r_neg_r <= 1'b0;
               end
`endif
            end
            ST_RUN: begin
               r_a   <= w_a_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt - C_ONE;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase

         if (r_state == ST_DONE) begin
            if (r_dbz_pend) begin
               r_quot <= {WIDTH{1'b1}};
               r_rem  <= r_q;
               r_dbz  <= 1'b1;
            end else begin
               r_quot <= w_neg_q ? f_neg(r_q) : r_q;
               r_rem  <= w_neg_r ? f_neg(r_a[WIDTH-1:0]) : r_a[WIDTH-1:0];
               r_dbz  <= 1'b0;
            end
         end else begin
            r_quot <= r_quot;
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_quot;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised unsigned restoring divider, one quotient bit per clock.
- Next generation of the 8-bit division datapath: the load/shift/output sequencing is now driven by an internal FSM instead of external strobes.
- Adds a start/busy/done handshake and divide-by-zero detection.
- Used as a shared arithmetic unit behind any controller that needs integer quotient and remainder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  WIDTH  numerator; captured on accepted start.
- divisor  in  WIDTH  denominator; captured on accepted start.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  registered quotient; held until next done.
- remainder  out  WIDTH  registered remainder; held until next done.
- div_by_zero  out  1  sticky with results; set when divisor was 0.

Behaviour:
Reset (rst_n low, asynchronous):
- State goes to IDLE; busy, done, div_by_zero, quotient, remainder all 0.
- Releasing reset mid-operation aborts it; no done is produced.

Datapath registers:
- A: WIDTH+1-bit partial remainder.
- Q: WIDTH-bit shifting dividend/quotient.
- M: WIDTH-bit divisor.

FSM IDLE, LOAD, RUN, DONE:
- IDLE: start=1 -> LOAD. Capture A=0, Q=dividend, M=divisor.
- LOAD: cnt=WIDTH.
  - M==0 -> DONE, with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
  - Otherwise -> RUN.
- RUN, each cycle:
  - Shift {A,Q} left by 1 and form T = A_shifted - {1'b0,M}.
  - T non-negative: A=T, Q[0]=1.
  - T negative: A=A_shifted, Q[0]=0.
  - cnt decrements; at cnt==1 the final step executes and the FSM goes to DONE.
- DONE: done=1 for exactly this cycle.
  - quotient=Q, remainder=A[WIDTH-1:0], div_by_zero=0 (unless set in LOAD).
  - start=1 -> LOAD, capturing new operands (back-to-back); otherwise -> IDLE.

Latency and handshake:
- Latency from start edge to done high: WIDTH+2 cycles for a nonzero divisor; 2 cycles for divide-by-zero.
- start while busy is ignored; operands on the inputs may change freely while busy.
- start held continuously produces back-to-back divisions with no idle cycle.
- Results are stable from done until the next done; they are not cleared on a new start.

Arithmetic boundaries:
- dividend < divisor -> quotient 0, remainder=dividend.
- divisor=1 -> quotient=dividend, remainder 0.
- dividend=0 -> quotient 0, remainder 0 (full latency still applies).

Optional Feature:
SIGNED_DIV_EN
- Defined:
  - Adds input port signed_op (1 bit, sampled with start).
  - When signed_op=1, operands are two's complement. Magnitudes are taken in LOAD and signs are fixed up in DONE, so latency is unchanged.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN/-1 -> quotient=MIN, remainder 0, no flag.
  - Divide-by-zero result is identical to unsigned mode.
- Undefined: no signed_op port; unsigned only.

Decomposition:
- Package div_pkg:
  - state enum div_state_t {IDLE, LOAD, RUN, DONE}.
  - DIV_DEFAULT_WIDTH=8.
  - Function clog2 helper, if the tool lacks $clog2.
- One sub-module, div_step: combinational, parametrised by WIDTH. Inputs A, Q, M; outputs the next A and Q for one restoring iteration. Instantiated once in seq_divider.

Test Plan:
- WIDTH=8, start with 7/2 -> done 10 cycles after the start edge; quotient 3, remainder 1, div_by_zero 0; busy high for 9 cycles.
- Back-to-back with start held: 2/2 then 66/5 -> done pulses 10 cycles apart; results 1 r0, then 13 r1; no IDLE cycle between them.
- 8/10 and 32/4 -> 0 r8 and 8 r0. Start pulsed again during RUN is ignored and the first result is unchanged.
- 66/0 -> done 2 cycles after start; quotient 0xFF, remainder 66, div_by_zero 1. The next 32/4 clears div_by_zero.
- rst_n asserted in RUN cycle 4 of 255/1 -> all outputs 0 immediately; no done pulse after release; a fresh 255/1 gives 255 r0.
- SIGNED_DIV_EN, WIDTH=8, signed_op=1: -7/2 -> -3 r-1; 7/-2 -> -3 r1; -128/-1 -> -128 r0. Also run WIDTH=16: 65535/255 -> 257 r0, done after 18 cycles.
